// File: rtl/pulse_train_gen.sv
// Programmable pulse-train transmitter: emits 'count' pulses of 'width' high cycles
// separated by max(gap,1) low cycles, with busy/done/pulse_idx status.
module pulse_train_gen #(
    parameter int unsigned WIDTH_W = 8,
    parameter int unsigned COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH_W-1:0] width,
    input  logic [WIDTH_W-1:0] gap,
    input  logic [COUNT_W-1:0] count,
    output logic               signal,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] pulse_idx
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

    state_t             state;
    logic [WIDTH_W-1:0] width_q;
    logic [WIDTH_W-1:0] gap_q;
    logic [COUNT_W-1:0] count_q;
    logic [WIDTH_W-1:0] cnt;

    logic [WIDTH_W-1:0] gap_eff_c;
    logic [COUNT_W-1:0] idx_next_c;

    // A zero gap still separates pulses by one low cycle
    assign gap_eff_c  = (gap_q == '0) ? WIDTH_W'(1) : gap_q;
    assign idx_next_c = pulse_idx + COUNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            width_q   <= '0;
            gap_q     <= '0;
            count_q   <= '0;
            cnt       <= '0;
            signal    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pulse_idx <= '0;
                        if (width != '0 && count != '0) begin
                            width_q <= width;
                            gap_q   <= gap;
                            count_q <= count;
                            cnt     <= WIDTH_W'(1);
                            signal  <= 1'b1;
                            busy    <= 1'b1;
                            state   <= HIGH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                HIGH: begin
                    if (cnt == width_q) begin
                        pulse_idx <= idx_next_c;
                        signal    <= 1'b0;
                        cnt       <= WIDTH_W'(1);
                        if (idx_next_c == count_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= LOW;
                        end
                    end else begin
                        cnt <= cnt + WIDTH_W'(1);
                    end
                end
                LOW: begin
                    if (cnt >= gap_eff_c) begin
                        signal <= 1'b1;
                        cnt    <= WIDTH_W'(1);
                        state  <= HIGH;
                    end else begin
                        cnt <= cnt + WIDTH_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
